config_write_arbiter: RTL and testbench

- Sequences all writes into the modulator's per-operator configuration memories: algorithm words and feedback levels.
- Arbitrates two requesters onto the single config write port, round-robin: the host register interface and the patch loader.
- Writes are gated to a short window after each frame start. This stops a voice from mixing old and new algorithm or feedback settings partway through a frame.
- Sits between the host/patch logic and the modulator stage. Its outputs drive the modulator's algorithm write enable, feedback write enable, config address and config data directly.

---
 rtl/config_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_config_write_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_write_arbiter.sv
// Round-robin arbiter for host and patch-loader writes into the modulator's
// per-operator config memories. Writes are gated to a window after each frame start.
module config_write_arbiter #(
    parameter int NUM_VOICE_OPERATORS = 128,
    parameter int WINDOW_CYCLES       = 16
) (
    input  logic                                   i_Clock,
    input  logic                                   i_Reset_n,
    input  logic                                   i_FrameStart,
    input  logic                                   i_HostValid,
    output logic                                   o_HostReady,
    input  logic [1:0]                             i_HostSelect,
    input  logic [$clog2(NUM_VOICE_OPERATORS)-1:0] i_HostAddr,
    input  logic [15:0]                            i_HostData,
    input  logic                                   i_LoadValid,
    output logic                                   o_LoadReady,
    input  logic [1:0]                             i_LoadSelect,
    input  logic [$clog2(NUM_VOICE_OPERATORS)-1:0] i_LoadAddr,
    input  logic [15:0]                            i_LoadData,
    output logic                                   o_AlgorithmWriteEnable,
    output logic                                   o_FeedbackLevelConfigWriteEnable,
    output logic [$clog2(NUM_VOICE_OPERATORS)-1:0] o_ConfigWriteAddr,
    output logic [15:0]                            o_ConfigWriteData,
    output logic                                   o_WindowOpen,
    output logic                                   o_BadSelect
);

    localparam int ADDR_W = $clog2(NUM_VOICE_OPERATORS);
    // A one-bit counter keeps the declarations legal when gating is disabled.
    localparam int CNT_W  = (WINDOW_CYCLES > 0) ? $clog2(WINDOW_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    localparam logic [1:0] SEL_ALGORITHM = 2'b00;
    localparam logic [1:0] SEL_FEEDBACK  = 2'b01;

    localparam logic LAST_HOST   = 1'b0;
    localparam logic LAST_LOADER = 1'b1;

    logic [CNT_W-1:0]  window_cnt_q, window_cnt_d;
    logic              last_q, last_d;
    logic              alg_we_q, alg_we_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              bad_q, bad_d;

    logic              window_open_s;
    logic              host_grant_s;
    logic              load_grant_s;
    logic              accept_s;
    logic [1:0]        sel_s;

    // Window is open while the counter runs, or always when gating is disabled; reset forces it shut.
    assign window_open_s = i_Reset_n && ((window_cnt_q != CNT_ZERO) || (WINDOW_CYCLES == 0));

    // Grant selection: a tie goes to whichever requester did not win the last transfer.
    always_comb begin
        host_grant_s = 1'b0;
        load_grant_s = 1'b0;
        if (window_open_s) begin
            case ({i_HostValid, i_LoadValid})
                2'b10: host_grant_s = 1'b1;
                2'b01: load_grant_s = 1'b1;
                2'b11: begin
                    if (last_q == LAST_LOADER) begin
                        host_grant_s = 1'b1;
                    end else begin
                        load_grant_s = 1'b1;
                    end
                end
                default: begin
                    host_grant_s = 1'b0;
                    load_grant_s = 1'b0;
                end
            endcase
        end else begin
            host_grant_s = 1'b0;
            load_grant_s = 1'b0;
        end
    end

    assign o_HostReady = host_grant_s;
    assign o_LoadReady = load_grant_s;
    assign accept_s    = (host_grant_s && i_HostValid) || (load_grant_s && i_LoadValid);
    assign sel_s       = load_grant_s ? i_LoadSelect : i_HostSelect;

    // Window counter: frame start reloads (never adds), otherwise count down to zero.
    always_comb begin
        window_cnt_d = window_cnt_q;
        if (i_FrameStart) begin
            window_cnt_d = WINDOW_LOAD;
        end else if (window_cnt_q != CNT_ZERO) begin
            window_cnt_d = window_cnt_q - CNT_ONE;
        end else begin
            window_cnt_d = window_cnt_q;
        end
    end

    // Write-port next state: strobes pulse for one cycle, address/data hold between accepts.
    always_comb begin
        alg_we_d = 1'b0;
        fb_we_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        bad_d    = bad_q;
        last_d   = last_q;
        if (accept_s) begin
            addr_d = load_grant_s ? i_LoadAddr : i_HostAddr;
            data_d = load_grant_s ? i_LoadData : i_HostData;
            last_d = load_grant_s ? LAST_LOADER : LAST_HOST;
            case (sel_s)
                SEL_ALGORITHM: alg_we_d = 1'b1;
                SEL_FEEDBACK:  fb_we_d  = 1'b1;
                default:       bad_d    = 1'b1;
            endcase
        end else begin
            alg_we_d = 1'b0;
            fb_we_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            window_cnt_q <= CNT_ZERO;
            last_q       <= LAST_LOADER;
            alg_we_q     <= 1'b0;
            fb_we_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= 16'h0000;
            bad_q        <= 1'b0;
        end else begin
            window_cnt_q <= window_cnt_d;
            last_q       <= last_d;
            alg_we_q     <= alg_we_d;
            fb_we_q      <= fb_we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            bad_q        <= bad_d;
        end
    end

    assign o_AlgorithmWriteEnable           = alg_we_q;
    assign o_FeedbackLevelConfigWriteEnable = fb_we_q;
    assign o_ConfigWriteAddr                = addr_q;
    assign o_ConfigWriteData                = data_q;
    assign o_WindowOpen                     = window_open_s;
    assign o_BadSelect                      = bad_q;

endmodule

// File: tb/tb_config_write_arbiter.sv
// Bench for config_write_arbiter: a gated instance (16-cycle window) and an ungated
// instance (window 0) run side by side against a request-queue reference model.
module tb_config_write_arbiter;

    typedef struct packed {
        logic [1:0]  sel;
        logic [6:0]  addr;
        logic [15:0] data;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fs;
    logic        hv [2];
    logic        lv [2];
    logic [1:0]  hs [2];
    logic [1:0]  ls [2];
    logic [6:0]  ha [2];
    logic [6:0]  la [2];
    logic [15:0] hd [2];
    logic [15:0] ld [2];
    logic        hr [2];
    logic        lr [2];
    logic        awe [2];
    logic        fwe [2];
    logic        wo [2];
    logic        bad [2];
    logic [6:0]  wa [2];
    logic [15:0] wd [2];

    config_write_arbiter #(.NUM_VOICE_OPERATORS(128), .WINDOW_CYCLES(16)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_FrameStart(fs),
        .i_HostValid(hv[0]), .o_HostReady(hr[0]), .i_HostSelect(hs[0]),
        .i_HostAddr(ha[0]), .i_HostData(hd[0]),
        .i_LoadValid(lv[0]), .o_LoadReady(lr[0]), .i_LoadSelect(ls[0]),
        .i_LoadAddr(la[0]), .i_LoadData(ld[0]),
        .o_AlgorithmWriteEnable(awe[0]), .o_FeedbackLevelConfigWriteEnable(fwe[0]),
        .o_ConfigWriteAddr(wa[0]), .o_ConfigWriteData(wd[0]),
        .o_WindowOpen(wo[0]), .o_BadSelect(bad[0])
    );

    config_write_arbiter #(.NUM_VOICE_OPERATORS(128), .WINDOW_CYCLES(0)) dut0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_FrameStart(fs),
        .i_HostValid(hv[1]), .o_HostReady(hr[1]), .i_HostSelect(hs[1]),
        .i_HostAddr(ha[1]), .i_HostData(hd[1]),
        .i_LoadValid(lv[1]), .o_LoadReady(lr[1]), .i_LoadSelect(ls[1]),
        .i_LoadAddr(la[1]), .i_LoadData(ld[1]),
        .o_AlgorithmWriteEnable(awe[1]), .o_FeedbackLevelConfigWriteEnable(fwe[1]),
        .o_ConfigWriteAddr(wa[1]), .o_ConfigWriteData(wd[1]),
        .o_WindowOpen(wo[1]), .o_BadSelect(bad[1])
    );

    int checks = 0;
    int errors = 0;

    // Pending requests per requester; the queue front is what the requester presents.
    req_t hq0[$], hq1[$], lq0[$], lq1[$];

    // Reference model state
    int          wsz [2] = '{16, 0};
    int          rem [2];
    bit          host_wins_tie [2];
    logic        m_awe [2];
    logic        m_fwe [2];
    logic        m_bad [2];
    logic [6:0]  m_addr [2];
    logic [15:0] m_data [2];
    bit          m_hr [2];
    bit          m_lr [2];

    int strobe_cnt0 = 0;
    int open_cnt0   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input bit host, input int k);
        if (host) return (k == 0) ? hq0.size() : hq1.size();
        else      return (k == 0) ? lq0.size() : lq1.size();
    endfunction

    function automatic req_t qfront(input bit host, input int k);
        req_t r;
        r = '0;
        if (qsize(host, k) != 0) begin
            if (host) r = (k == 0) ? hq0[0] : hq1[0];
            else      r = (k == 0) ? lq0[0] : lq1[0];
        end
        return r;
    endfunction

    task automatic qpush(input bit host, input int k, input req_t r);
        if (host) begin
            if (k == 0) hq0.push_back(r); else hq1.push_back(r);
        end else begin
            if (k == 0) lq0.push_back(r); else lq1.push_back(r);
        end
    endtask

    task automatic qpop(input bit host, input int k);
        if (host) begin
            if (k == 0) void'(hq0.pop_front()); else void'(hq1.pop_front());
        end else begin
            if (k == 0) void'(lq0.pop_front()); else void'(lq1.pop_front());
        end
    endtask

    task automatic clear_queues();
        hq0.delete(); hq1.delete(); lq0.delete(); lq1.delete();
    endtask

    function automatic req_t mkreq(input logic [1:0] sel, input logic [6:0] addr, input logic [15:0] data);
        req_t r;
        r.sel = sel; r.addr = addr; r.data = data;
        return r;
    endfunction

    function automatic req_t rand_req();
        logic [1:0] s;
        s = ($urandom_range(0, 19) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
        return mkreq(s, 7'($urandom), 16'($urandom));
    endfunction

    task automatic model_reset(input int k);
        rem[k] = 0;
        host_wins_tie[k] = 1'b1;
        m_awe[k] = 1'b0; m_fwe[k] = 1'b0; m_bad[k] = 1'b0;
        m_addr[k] = 7'h00; m_data[k] = 16'h0000;
    endtask

    task automatic drive_inputs();
        req_t r;
        for (int k = 0; k < 2; k++) begin
            r = qfront(1'b1, k);
            hv[k] = (qsize(1'b1, k) != 0);
            {hs[k], ha[k], hd[k]} = r;
            r = qfront(1'b0, k);
            lv[k] = (qsize(1'b0, k) != 0);
            {ls[k], la[k], ld[k]} = r;
        end
    endtask

    // One clock: present inputs, check at the falling edge, advance the model at the rising edge.
    task automatic run_cycle();
        bit   open;
        bit   acc;
        req_t r;
        drive_inputs();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            open = rst_n && (rem[k] > 0 || wsz[k] == 0);
            m_hr[k] = open && hv[k] && (!lv[k] || host_wins_tie[k]);
            m_lr[k] = open && lv[k] && !m_hr[k];
            check_eq($sformatf("host_ready%0d", k), 32'(hr[k]), 32'(m_hr[k]));
            check_eq($sformatf("load_ready%0d", k), 32'(lr[k]), 32'(m_lr[k]));
            check_eq($sformatf("window%0d", k), 32'(wo[k]), 32'(open));
            check_eq($sformatf("alg_we%0d", k), 32'(awe[k]), 32'(m_awe[k]));
            check_eq($sformatf("fb_we%0d", k), 32'(fwe[k]), 32'(m_fwe[k]));
            check_eq($sformatf("addr%0d", k), 32'(wa[k]), 32'(m_addr[k]));
            check_eq($sformatf("data%0d", k), 32'(wd[k]), 32'(m_data[k]));
            check_eq($sformatf("bad%0d", k), 32'(bad[k]), 32'(m_bad[k]));
        end
        if (awe[0] === 1'b1) strobe_cnt0++;
        if (wo[0] === 1'b1) open_cnt0++;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                model_reset(k);
            end else begin
                acc = m_hr[k] || m_lr[k];
                r = qfront(m_hr[k], k);
                m_awe[k] = acc && (r.sel == 2'b00);
                m_fwe[k] = acc && (r.sel == 2'b01);
                if (acc) begin
                    m_addr[k] = r.addr;
                    m_data[k] = r.data;
                    if (r.sel[1]) m_bad[k] = 1'b1;
                    host_wins_tie[k] = m_lr[k];
                    qpop(m_hr[k], k);
                end
                if (fs) rem[k] = wsz[k];
                else if (rem[k] > 0) rem[k] = rem[k] - 1;
            end
        end
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic pulse_frame();
        fs = 1'b1;
        run_cycle();
        fs = 1'b0;
    endtask

    task automatic reset_and_flush();
        clear_queues();
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        fs = 1'b0;
        clear_queues();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);

        // Reset with both requesters valid, then release: gated instance waits for a frame start.
        for (int k = 0; k < 2; k++) begin
            qpush(1'b1, k, mkreq(2'b00, 7'h11, 16'hAAAA));
            qpush(1'b0, k, mkreq(2'b01, 7'h22, 16'hBBBB));
        end
        run_n(2);
        rst_n = 1'b1;
        run_n(4);
        check_eq("held_before_frame", 32'(hq0.size() + lq0.size()), 32'd2);
        pulse_frame();
        run_n(4);

        // Host streams 20 algorithm writes: 16 in the first window, 4 in the next.
        reset_and_flush();
        for (int a = 0; a < 20; a++) qpush(1'b1, 0, mkreq(2'b00, 7'(a), 16'(16'h0100 + a)));
        strobe_cnt0 = 0;
        pulse_frame();
        run_n(24);
        check_eq("stream_first_window", 32'(strobe_cnt0), 32'd16);
        strobe_cnt0 = 0;
        pulse_frame();
        run_n(8);
        check_eq("stream_second_window", 32'(strobe_cnt0), 32'd4);

        // Both requesters continuously valid: alternate starting with host; loader feedback write.
        reset_and_flush();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) qpush(1'b1, k, mkreq(2'b00, 7'(8'h40 + i), 16'(16'h1000 + i)));
            for (int i = 0; i < 3; i++) qpush(1'b0, k, mkreq(2'b00, 7'(8'h50 + i), 16'(16'h2000 + i)));
            qpush(1'b0, k, mkreq(2'b01, 7'h05, 16'h00C3));
        end
        pulse_frame();
        run_n(10);

        // Re-pulse at counter 3: 13 cycles (16..4), the pulse cycle itself (3), then a fresh 16.
        reset_and_flush();
        open_cnt0 = 0;
        pulse_frame();
        run_n(13);
        pulse_frame();
        run_n(20);
        check_eq("repulse_open_cycles", 32'(open_cnt0), 32'd30);

        // Reserved select is accepted, flags bad sticky, emits no strobe.
        reset_and_flush();
        qpush(1'b1, 0, mkreq(2'b10, 7'h7F, 16'h1234));
        qpush(1'b1, 1, mkreq(2'b11, 7'h7F, 16'h4321));
        pulse_frame();
        run_n(3);
        check_eq("bad_sticky0", 32'(bad[0]), 32'd1);
        run_n(20);
        check_eq("bad_sticky1", 32'(bad[1]), 32'd1);

        // Ungated instance: loader stream interrupted by reset mid-stream.
        reset_and_flush();
        for (int i = 0; i < 6; i++) qpush(1'b0, 1, mkreq(2'b01, 7'(i), 16'(16'h0C00 + i)));
        qpush(1'b1, 1, mkreq(2'b00, 7'h33, 16'h3333));
        run_n(2);
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        run_n(8);

        // Randomized traffic with occasional frame starts and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (qsize(1'b1, k) < 3 && $urandom_range(0, 2) == 0) qpush(1'b1, k, rand_req());
                if (qsize(1'b0, k) < 3 && $urandom_range(0, 2) == 0) qpush(1'b0, k, rand_req());
            end
            fs = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 249) != 0);
            run_cycle();
        end
        fs = 1'b0;
        rst_n = 1'b1;
        run_n(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
